// File: rtl/bod_adc_sampler.sv
// Periodic brownout sampler: drives a 20-bit serial ADC, captures each sample
// and raises warning/critical flags with hysteresis against two thresholds.
module bod_adc_sampler #(
   parameter int SCK_DIV     = 4,
   parameter int CONV_CYCLES = 40,
   parameter int PERIOD      = 1000,
   parameter int HYST        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [19:0] warn_th,
   input  logic [19:0] crit_th,
   input  logic        adc_sdo,
   output logic        adc_cnv,
   output logic        adc_sck,
   output logic [19:0] adc_data,
   output logic        data_valid,
   output logic        BOD_out1,
   output logic        BOD_out2,
   output logic        busy,
   output logic        overrun
);

   localparam int CW   = $clog2(PERIOD + 1);
   localparam int TMAX = (SCK_DIV > CONV_CYCLES) ? SCK_DIV : CONV_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, UPDATE} state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   tmr;
   logic [5:0]      half_cnt;
   logic [19:0]     shreg;
   logic            trigger;
   logic            sck_tick;
   logic            conv_done;
   logic            last_half;
   logic            cnv_nx;
   logic            sck_nx;
   logic            dv_nx;

   assign trigger   = enable && (cnt == '0);
   assign sck_tick  = (tmr == TW'(SCK_DIV - 1));
   assign conv_done = (tmr == TW'(CONV_CYCLES - 1));
   assign last_half = (half_cnt == 6'd39);
   assign busy      = (state != IDLE);

   // Flag sets below th, clears at or above th+HYST (saturated), holds between.
   function automatic logic hyst_flag(input logic cur, input logic [19:0] s,
                                      input logic [19:0] th);
      logic [20:0] sum;
      logic [19:0] clr;
      logic        res;
      sum = {1'b0, th} + 21'(HYST);
      clr = sum[20] ? 20'hFFFFF : sum[19:0];
      res = cur;
      if (s < th)
         res = 1'b1;
      else if (s >= clr)
         res = 1'b0;
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (trigger) state_nx = CONVERT;
         CONVERT: if (conv_done) state_nx = SHIFT;
         SHIFT:   if (sck_tick && last_half) state_nx = UPDATE;
         UPDATE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs; sck only toggles while staying in SHIFT.
   always_comb begin
      cnv_nx = (state_nx == CONVERT);
      sck_nx = 1'b0;
      if (state == SHIFT && state_nx == SHIFT)
         sck_nx = sck_tick ? ~adc_sck : adc_sck;
      dv_nx  = (state == UPDATE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_cnv    <= 1'b0;
         adc_sck    <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         adc_cnv    <= cnv_nx;
         adc_sck    <= sck_nx;
         data_valid <= dv_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         tmr      <= '0;
         half_cnt <= '0;
         shreg    <= '0;
         adc_data <= '0;
         BOD_out1 <= 1'b0;
         BOD_out2 <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (!enable || cnt == CW'(PERIOD - 1))
            cnt <= '0;
         else
            cnt <= cnt + CW'(1);

         if (trigger && state != IDLE)
            overrun <= 1'b1;

         case (state)
            CONVERT: tmr <= conv_done ? '0 : tmr + TW'(1);
            SHIFT:   tmr <= sck_tick ? '0 : tmr + TW'(1);
            default: tmr <= '0;
         endcase

         if (state != SHIFT)
            half_cnt <= '0;
         else if (sck_tick)
            half_cnt <= half_cnt + 6'd1;

         // Capture on the tick that raises adc_sck.
         if (state == SHIFT && sck_tick && !adc_sck)
            shreg <= {shreg[18:0], adc_sdo};

         if (state == UPDATE) begin
            adc_data <= shreg;
            BOD_out1 <= hyst_flag(BOD_out1, shreg, warn_th);
            BOD_out2 <= hyst_flag(BOD_out2, shreg, crit_th);
         end
      end
   end

endmodule

// File: tb/tb_bod_adc_sampler.sv
// Bench for bod_adc_sampler: table vectors, randomized samples against a
// threshold/hysteresis model, enable-drop, mid-shift reset and overrun cases.
module tb_bod_adc_sampler;

   localparam int PERIOD = 1000;
   localparam int HYST   = 16;
   localparam int NVEC   = 13;
   localparam int NRAND  = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [19:0] warn_th;
   logic [19:0] crit_th;
   logic        adc_sdo = 1'b0;
   logic        adc_cnv;
   logic        adc_sck;
   logic [19:0] adc_data;
   logic        data_valid;
   logic        BOD_out1;
   logic        BOD_out2;
   logic        busy;
   logic        overrun;

   logic        rst2_n;
   logic        en2;
   logic        ov_sdo = 1'b0;
   logic        ov_cnv;
   logic        ov_sck;
   logic [19:0] ov_data;
   logic        ov_dv;
   logic        ov_b1;
   logic        ov_b2;
   logic        ov_busy;
   logic        ov_overrun;

   bod_adc_sampler dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .warn_th(warn_th), .crit_th(crit_th),
      .adc_sdo(adc_sdo), .adc_cnv(adc_cnv), .adc_sck(adc_sck), .adc_data(adc_data),
      .data_valid(data_valid), .BOD_out1(BOD_out1), .BOD_out2(BOD_out2),
      .busy(busy), .overrun(overrun)
   );

   bod_adc_sampler #(.PERIOD(150)) dut_ov (
      .clk(clk), .rst_n(rst2_n), .enable(en2), .warn_th(20'd0), .crit_th(20'd0),
      .adc_sdo(ov_sdo), .adc_cnv(ov_cnv), .adc_sck(ov_sck), .adc_data(ov_data),
      .data_valid(ov_dv), .BOD_out1(ov_b1), .BOD_out2(ov_b2),
      .busy(ov_busy), .overrun(ov_overrun)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ADC model and transaction monitor
   logic [19:0] adc_word  = 20'd0;
   logic [19:0] conv_word = 20'd0;
   logic        prev_cnv  = 1'b0;
   logic        prev_sck  = 1'b0;
   int cyc = 0, trig_cyc = 0, rises = 0, cnv_hi = 0, sck_hi = 0;
   int last_lat = 0, last_cnv_hi = 0, last_sck_hi = 0, last_rises = 0;
   int dv_count = 0, cnv_rise_count = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (adc_cnv && !prev_cnv) begin
         conv_word = adc_word;
         rises     = 0;
         trig_cyc  = cyc;
         cnv_hi    = 0;
         sck_hi    = 0;
         cnv_rise_count++;
      end
      if (adc_cnv) cnv_hi++;
      if (adc_sck) sck_hi++;
      if (adc_sck && !prev_sck) rises++;
      if (data_valid) begin
         dv_count++;
         last_lat    = cyc - trig_cyc;
         last_cnv_hi = cnv_hi;
         last_sck_hi = sck_hi;
         last_rises  = rises;
      end
      adc_sdo  = (rises < 20) ? conv_word[19 - rises] : 1'b0;
      prev_cnv = adc_cnv;
      prev_sck = adc_sck;
   end

   // scoreboard helpers
   task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_dv(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (data_valid) ok = 1'b1;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_data_valid: no pulse within %0d cycles, required one", budget);
      end
   endtask

   task automatic wait_cnv(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (adc_cnv) ok = 1'b1;
      end
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wait_adc_cnv: no conversion within %0d cycles, required one", budget);
      end
   endtask

   // Reference rule: below th -> 1; at/above min(th+HYST, max code) -> 0; else hold.
   function automatic logic model_flag(input logic cur, input int unsigned s,
                                       input int unsigned th);
      int unsigned clr;
      clr = th + HYST;
      if (clr > 32'hFFFFF) clr = 32'hFFFFF;
      if (s < th) return 1'b1;
      if (s >= clr) return 1'b0;
      return cur;
   endfunction

   function automatic logic [19:0] near_th(input int unsigned s);
      int v;
      if ($urandom_range(0, 3) == 0) return 20'($urandom_range(0, 32'hFFFFF));
      v = int'(s) + int'($urandom_range(0, 48)) - 24;
      if (v < 0) v = 0;
      if (v > 32'hFFFFF) v = 32'hFFFFF;
      return 20'(v);
   endfunction

   typedef struct {
      logic [19:0] sample;
      logic [19:0] warn;
      logic [19:0] crit;
      logic        b1;
      logic        b2;
   } vec_t;

   vec_t vecs [NVEC];

   initial begin
      bit          ok;
      logic        m_b1;
      logic        m_b2;
      int unsigned s;
      int          dv0;
      int          cr0;

      vecs[0]  = '{20'h12345, 20'd1000,    20'd500, 1'b0, 1'b0};
      vecs[1]  = '{20'd1200,  20'd1000,    20'd0,   1'b0, 1'b0};
      vecs[2]  = '{20'd999,   20'd1000,    20'd0,   1'b1, 1'b0};
      vecs[3]  = '{20'd1010,  20'd1000,    20'd0,   1'b1, 1'b0};
      vecs[4]  = '{20'd1016,  20'd1000,    20'd0,   1'b0, 1'b0};
      vecs[5]  = '{20'd400,   20'd1000,    20'd500, 1'b1, 1'b1};
      vecs[6]  = '{20'd520,   20'd1000,    20'd500, 1'b1, 1'b0};
      vecs[7]  = '{20'd100,   20'd1000,    20'd500, 1'b1, 1'b1};
      vecs[8]  = '{20'd510,   20'd1000,    20'd500, 1'b1, 1'b1};
      vecs[9]  = '{20'd2000,  20'd1000,    20'd500, 1'b0, 1'b0};
      vecs[10] = '{20'hFFFF0, 20'hFFFF8,   20'd500, 1'b1, 1'b0};
      vecs[11] = '{20'hFFFFE, 20'hFFFF8,   20'd500, 1'b1, 1'b0};
      vecs[12] = '{20'hFFFFF, 20'hFFFF8,   20'd500, 1'b0, 1'b0};

      rst_n    = 1'b0;
      enable   = 1'b0;
      rst2_n   = 1'b0;
      en2      = 1'b0;
      warn_th  = vecs[0].warn;
      crit_th  = vecs[0].crit;
      adc_word = vecs[0].sample;
      repeat (3) @(negedge clk);

      check("rst_adc_cnv",    20'(adc_cnv),    20'd0);
      check("rst_adc_sck",    20'(adc_sck),    20'd0);
      check("rst_data_valid", 20'(data_valid), 20'd0);
      check("rst_busy",       20'(busy),       20'd0);
      check("rst_overrun",    20'(overrun),    20'd0);
      check("rst_bod1",       20'(BOD_out1),   20'd0);
      check("rst_bod2",       20'(BOD_out2),   20'd0);
      check("rst_adc_data",   adc_data,        20'd0);

      // First trigger on the first posedge after reset release.
      enable = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);
      check("first_trigger_cnv",  20'(adc_cnv), 20'd1);
      check("first_trigger_busy", 20'(busy),    20'd1);

      for (int i = 0; i < NVEC; i++) begin
         if (i > 0) begin
            warn_th  = vecs[i].warn;
            crit_th  = vecs[i].crit;
            adc_word = vecs[i].sample;
         end
         wait_dv(2 * PERIOD, ok);
         #1;
         check($sformatf("vec%0d_data", i), adc_data, vecs[i].sample);
         check($sformatf("vec%0d_bod1", i), 20'(BOD_out1), 20'(vecs[i].b1));
         check($sformatf("vec%0d_bod2", i), 20'(BOD_out2), 20'(vecs[i].b2));
         if (i == 0) begin
            check("latency",      20'(last_lat),    20'd201);
            check("cnv_high",     20'(last_cnv_hi), 20'd40);
            check("sck_rises",    20'(last_rises),  20'd20);
            check("sck_high",     20'(last_sck_hi), 20'd80);
            @(negedge clk);
            check("dv_one_cycle", 20'(data_valid),  20'd0);
         end
      end
      m_b1 = vecs[NVEC-1].b1;
      m_b2 = vecs[NVEC-1].b2;

      for (int k = 0; k < NRAND; k++) begin
         s = $urandom_range(0, 32'hFFFFF);
         if ($urandom_range(0, 5) == 0) s = 32'hFFFFF - $urandom_range(0, 24);
         adc_word = 20'(s);
         warn_th  = near_th(s);
         crit_th  = near_th(s);
         m_b1 = model_flag(m_b1, s, warn_th);
         m_b2 = model_flag(m_b2, s, crit_th);
         wait_dv(2 * PERIOD, ok);
         #1;
         check($sformatf("rand%0d_data", k), adc_data, 20'(s));
         check($sformatf("rand%0d_bod1", k), 20'(BOD_out1), 20'(m_b1));
         check($sformatf("rand%0d_bod2", k), 20'(BOD_out2), 20'(m_b2));
      end

      // Enable dropped 10 cycles into SHIFT: transaction still completes once.
      s = $urandom_range(0, 32'hFFFFF);
      adc_word = 20'(s);
      m_b1 = model_flag(m_b1, s, warn_th);
      m_b2 = model_flag(m_b2, s, crit_th);
      wait_cnv(2 * PERIOD, ok);
      repeat (50) @(negedge clk);
      enable = 1'b0;
      dv0 = dv_count;
      wait_dv(2 * PERIOD, ok);
      #1;
      check("endrop_data", adc_data, 20'(s));
      check("endrop_bod1", 20'(BOD_out1), 20'(m_b1));
      check("endrop_bod2", 20'(BOD_out2), 20'(m_b2));
      cr0 = cnv_rise_count;
      repeat (2 * PERIOD) @(negedge clk);
      check("endrop_dv_count", 20'(dv_count - dv0), 20'd1);
      check("endrop_no_cnv",   20'(cnv_rise_count - cr0), 20'd0);

      // Reset in the middle of SHIFT while adc_sck is high.
      adc_word = 20'hABCDE;
      enable = 1'b1;
      wait_cnv(10, ok);
      repeat (50) @(negedge clk);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (adc_sck) ok = 1'b1;
         else @(negedge clk);
      end
      check("midshift_sck_seen_high", 20'(ok), 20'd1);
      #2;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      check("midrst_sck",  20'(adc_sck),  20'd0);
      check("midrst_cnv",  20'(adc_cnv),  20'd0);
      check("midrst_busy", 20'(busy),     20'd0);
      check("midrst_data", adc_data,      20'd0);
      check("midrst_bod1", 20'(BOD_out1), 20'd0);
      dv0 = dv_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("midrst_no_dv", 20'(dv_count - dv0), 20'd0);

      // Overrun with a period shorter than one transaction.
      en2    = 1'b1;
      rst2_n = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      check("ov_before_second_trigger", 20'(ov_overrun), 20'd0);
      @(posedge clk);
      #1;
      check("ov_at_second_trigger", 20'(ov_overrun), 20'd1);
      repeat (300) @(posedge clk);
      #1;
      check("ov_sticky", 20'(ov_overrun), 20'd1);
      check("main_no_overrun", 20'(overrun), 20'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
